wta_sequencer: RTL and testbench

WTA_SEQUENCER -- requirements
Module: wta_sequencer

---
 rtl/wta_pkg.sv | 25 ++
 rtl/comp_4in.sv | 33 +++
 rtl/wta_sequencer.sv | 132 +++++++++++++
 tb/tb_wta_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wta_pkg.sv
// Shared definitions for the winner-take-all sequencer: sizes, FSM states
// and the one-hot to binary encoder used when reporting the winning index.
package wta_pkg;

  localparam int N_NEURONS  = 8;
  localparam int GROUP_SIZE = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CMP_LO  = 2'd1,
    CMP_HI  = 2'd2,
    RESOLVE = 2'd3
  } wta_state_e;

  // An all-zero one-hot word encodes to position 0.
  function automatic logic [1:0] onehot_to_bin(input logic [GROUP_SIZE-1:0] oh);
    logic [1:0] b;
    b = '0;
    for (int i = GROUP_SIZE - 1; i >= 0; i--) begin
      if (oh[i]) b = 2'(i);
    end
    return b;
  endfunction

endpackage

// File: rtl/comp_4in.sv
// Four-input maximum finder shared by both neuron groups. Ties go to the
// lowest input; an all-zero input set yields a zero one-hot index.
module comp_4in
  import wta_pkg::*;
#(
  parameter int p_width = 19
) (
  input  logic [GROUP_SIZE*p_width-1:0] i_val,
  output logic [p_width-1:0]            o_max,
  output logic [GROUP_SIZE-1:0]         o_onehot
);

  logic [p_width-1:0] best;
  logic [1:0]         best_idx;

  always_comb begin
    best     = i_val[0 +: p_width];
    best_idx = '0;
    for (int k = 1; k < GROUP_SIZE; k++) begin
      if (i_val[k*p_width +: p_width] > best) begin
        best     = i_val[k*p_width +: p_width];
        best_idx = 2'(k);
      end
    end
  end

  always_comb begin
    o_max    = best;
    o_onehot = '0;
    if (best != '0) o_onehot[best_idx] = 1'b1;
  end

endmodule

// File: rtl/wta_sequencer.sv
// Winner-take-all search over eight membrane potentials using one shared
// 4-input comparator over two cycles. Optional macro: WTA_THRESHOLD_EN.
//
// state   | meaning
// IDLE    | waiting for i_start; potentials latched on accept
// CMP_LO  | comparator on neurons 0-3, result into best_lo
// CMP_HI  | comparator on neurons 4-7, result into best_hi
// RESOLVE | pick lower group on ties, update outputs, pulse o_valid
module wta_sequencer
  import wta_pkg::*;
#(
  parameter int p_width  = 19,
  parameter int p_thresh = 0
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_start,
  input  logic [N_NEURONS*p_width-1:0]   i_pot,
  output logic                           o_busy,
  output logic                           o_valid,
  output logic [2:0]                     o_winner,
  output logic [p_width-1:0]             o_value,
  output logic                           o_none
);

  wta_state_e state, state_nxt;

  logic [p_width-1:0]            pot_rf [N_NEURONS];
  logic [p_width-1:0]            lo_val, hi_val;
  logic [GROUP_SIZE-1:0]         lo_oh, hi_oh;

  logic [GROUP_SIZE*p_width-1:0] cmp_in;
  logic [p_width-1:0]            cmp_max;
  logic [GROUP_SIZE-1:0]         cmp_oh;

  logic                          sel_hi;
  logic [p_width-1:0]            sel_val;
  logic [2:0]                    sel_winner;
  logic                          sel_none;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start) state_nxt = CMP_LO;
      CMP_LO:  state_nxt = CMP_HI;
      CMP_HI:  state_nxt = RESOLVE;
      RESOLVE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign o_busy = (state != IDLE);

  // Single comparator, input group chosen by state.
  always_comb begin
    cmp_in = '0;
    for (int g = 0; g < GROUP_SIZE; g++) begin
      cmp_in[g*p_width +: p_width] = (state == CMP_HI) ? pot_rf[GROUP_SIZE + g] : pot_rf[g];
    end
  end

  comp_4in #(.p_width(p_width)) u_comp (
    .i_val    (cmp_in),
    .o_max    (cmp_max),
    .o_onehot (cmp_oh)
  );

`ifdef WTA_THRESHOLD_EN
  localparam logic [p_width-1:0] thresh_v = p_width'(p_thresh);
`else
  logic unused_thresh;
  assign unused_thresh = (p_thresh != 0);
`endif

  always_comb begin
    sel_hi     = (hi_val > lo_val);
    sel_val    = sel_hi ? hi_val : lo_val;
    sel_winner = sel_hi ? {1'b1, onehot_to_bin(hi_oh)} : {1'b0, onehot_to_bin(lo_oh)};
    sel_none   = (sel_val == '0);
`ifdef WTA_THRESHOLD_EN
    if (sel_val < thresh_v) sel_none = 1'b1;
`endif
    if (sel_none) begin
      sel_val    = '0;
      sel_winner = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < N_NEURONS; k++) pot_rf[k] <= '0;
      lo_val   <= '0;
      lo_oh    <= '0;
      hi_val   <= '0;
      hi_oh    <= '0;
      o_valid  <= 1'b0;
      o_winner <= '0;
      o_value  <= '0;
      o_none   <= 1'b1;
    end else begin
      o_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            for (int k = 0; k < N_NEURONS; k++) pot_rf[k] <= i_pot[k*p_width +: p_width];
          end
        end
        CMP_LO: begin
          lo_val <= cmp_max;
          lo_oh  <= cmp_oh;
        end
        CMP_HI: begin
          hi_val <= cmp_max;
          hi_oh  <= cmp_oh;
        end
        RESOLVE: begin
          o_valid  <= 1'b1;
          o_winner <= sel_winner;
          o_value  <= sel_val;
          o_none   <= sel_none;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wta_sequencer.sv
// Self-checking bench for wta_sequencer: directed vector table, busy/reset
// corner sequences and randomized searches against a behavioural max model.
module tb_wta_sequencer;

  localparam int W  = 19;
  localparam int TH = 10;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [8*W-1:0] pot;
  logic           busy;
  logic           valid;
  logic [2:0]     winner;
  logic [W-1:0]   value;
  logic           none;

  int tests = 0;
  int fails = 0;

  wta_sequencer #(.p_width(W), .p_thresh(TH)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_start  (start),
    .i_pot    (pot),
    .o_busy   (busy),
    .o_valid  (valid),
    .o_winner (winner),
    .o_value  (value),
    .o_none   (none)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [8*W-1:0] pot;
    logic [2:0]     w;
    logic [W-1:0]   v;
    logic           n;
    string          name;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [8*W-1:0] mk(input int a0, a1, a2, a3, a4, a5, a6, a7);
    logic [8*W-1:0] r;
    r = {W'(a7), W'(a6), W'(a5), W'(a4), W'(a3), W'(a2), W'(a1), W'(a0)};
    return r;
  endfunction

  // Maximum over all eight, first occurrence wins; zero or sub-threshold is "none".
  task automatic model(input logic [8*W-1:0] p, output logic [2:0] w,
                       output logic [W-1:0] v, output logic n);
    logic [W-1:0] best;
    int           bi;
    best = '0;
    bi   = 0;
    for (int k = 0; k < 8; k++) begin
      if (p[k*W +: W] > best) begin
        best = p[k*W +: W];
        bi   = k;
      end
    end
    n = (best == '0);
`ifdef WTA_THRESHOLD_EN
    if (best < W'(TH)) n = 1'b1;
`endif
    if (n) begin
      best = '0;
      bi   = 0;
    end
    w = 3'(bi);
    v = best;
  endtask

  function automatic logic [8*W-1:0] rand_pot();
    logic [8*W-1:0] r;
    int mode;
    mode = $urandom_range(0, 2);
    for (int k = 0; k < 8; k++) begin
      case (mode)
        0:       r[k*W +: W] = W'($urandom_range(0, 15));
        1:       r[k*W +: W] = W'($urandom);
        default: r[k*W +: W] = ($urandom_range(0, 3) == 0) ? W'($urandom_range(1, 40)) : '0;
      endcase
    end
    return r;
  endfunction

  // Drive one start pulse; pot is scrambled afterwards to show it is latched.
  task automatic launch(input logic [8*W-1:0] p);
    start = 1'b1;
    pot   = p;
    @(posedge clk);
    #1;
    start = 1'b0;
    pot   = rand_pot();
  endtask

  task automatic wait_valid(output int lat);
    lat = 99;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1;
      if (valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic chk_result(input string name, input logic [2:0] w,
                            input logic [W-1:0] v, input logic n);
    chk({name, "_winner"}, 32'(winner), 32'(w));
    chk({name, "_value"},  32'(value),  32'(v));
    chk({name, "_none"},   32'(none),   32'(n));
  endtask

  task automatic run_search(input logic [8*W-1:0] p, input logic [2:0] w,
                            input logic [W-1:0] v, input logic n, input string name);
    int lat;
    @(posedge clk);
    #1;
    launch(p);
    chk({name, "_busy"}, 32'(busy), 32'd1);
    wait_valid(lat);
    chk({name, "_latency"}, 32'(lat), 32'd3);
    chk_result(name, w, v, n);
  endtask

  vec_t           vecs [7];
  logic [2:0]     ew;
  logic [W-1:0]   ev;
  logic           en;
  logic [8*W-1:0] pa, pb;
  int             lat, pulses;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    pot   = '0;

    vecs[0] = '{mk(5, 9, 3, 1, 7, 2, 8, 4),   3'd1, W'(9),      1'b0, "distinct"};
    vecs[1] = '{mk(0, 0, 12, 0, 0, 0, 12, 0), 3'd2, W'(12),     1'b0, "tie_across"};
    vecs[2] = '{mk(0, 0, 0, 0, 3, 3, 0, 0),   3'd4, W'(3),      1'b0, "tie_within"};
    vecs[3] = '{mk(0, 0, 0, 0, 0, 0, 0, 0),   3'd0, W'(0),      1'b1, "all_zero"};
    vecs[4] = '{mk(1, 1, 1, 1, 1, 1, 1, 2),   3'd7, W'(2),      1'b0, "max_last"};
    vecs[5] = '{mk(6, 6, 6, 6, 6, 6, 6, 6),   3'd0, W'(6),      1'b0, "all_equal"};
    vecs[6] = '{mk(0, 1, 2, 524287, 9, 0, 524287, 3), 3'd3, W'(524287), 1'b0, "full_scale"};
`ifdef WTA_THRESHOLD_EN
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].v < W'(TH)) begin
        vecs[i].w = '0;
        vecs[i].v = '0;
        vecs[i].n = 1'b1;
      end
    end
`endif

    #12;
    chk("rst_busy",   32'(busy),   32'd0);
    chk("rst_valid",  32'(valid),  32'd0);
    chk("rst_winner", 32'(winner), 32'd0);
    chk("rst_value",  32'(value),  32'd0);
    chk("rst_none",   32'(none),   32'd1);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 7; i++)
      run_search(vecs[i].pot, vecs[i].w, vecs[i].v, vecs[i].n, vecs[i].name);

    // Outputs hold between pulses while inputs wander.
    run_search(mk(5, 9, 3, 1, 7, 2, 8, 4), 3'd1, W'(9), 1'b0, "pre_hold");
    for (int c = 0; c < 3; c++) begin
      pot = rand_pot();
      @(posedge clk);
      #1;
      chk("hold_valid", 32'(valid), 32'd0);
      chk_result("hold", 3'd1, W'(9), 1'b0);
    end

    // Second start during CMP_HI is dropped.
    pa = mk(0, 0, 0, 0, 0, 30, 0, 0);
    pb = mk(50, 0, 0, 0, 0, 0, 0, 0);
    model(pa, ew, ev, en);
    @(posedge clk);
    #1;
    launch(pa);
    @(posedge clk);
    #1;
    start = 1'b1;
    pot   = pb;
    @(posedge clk);
    #1;
    start  = 1'b0;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (valid) begin
        pulses++;
        chk_result("busy_ignore", ew, ev, en);
      end
    end
    chk("busy_ignore_pulses", 32'(pulses), 32'd1);

    // Start in the o_valid cycle is accepted; next result 4 cycles later.
    @(posedge clk);
    #1;
    launch(mk(1, 2, 3, 4, 5, 6, 7, 8));
    wait_valid(lat);
    chk("b2b_first_latency", 32'(lat), 32'd3);
    pa = mk(40, 0, 0, 41, 0, 0, 0, 41);
    model(pa, ew, ev, en);
    launch(pa);
    wait_valid(lat);
    chk("b2b_second_latency", 32'(lat + 1), 32'd4);
    chk_result("b2b", ew, ev, en);

    // Reset during CMP_HI aborts the search immediately.
    run_search(mk(5, 9, 3, 1, 7, 2, 8, 4), 3'd1, W'(9), 1'b0, "pre_reset");
    @(posedge clk);
    #1;
    launch(mk(0, 0, 0, 0, 0, 0, 77, 0));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy",   32'(busy),   32'd0);
    chk("midrst_valid",  32'(valid),  32'd0);
    chk_result("midrst", 3'd0, W'(0), 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (valid) pulses++;
    end
    chk("midrst_no_valid", 32'(pulses), 32'd0);
    pa = mk(0, 0, 0, 0, 0, 20, 0, 0);
    model(pa, ew, ev, en);
    run_search(pa, ew, ev, en, "post_reset");

`ifdef WTA_THRESHOLD_EN
    run_search(mk(9, 0, 3, 0, 0, 0, 0, 1),  3'd0, W'(0),  1'b1, "thr_below");
    run_search(mk(0, 0, 10, 0, 0, 0, 4, 0), 3'd2, W'(10), 1'b0, "thr_equal");
`endif

    for (int r = 0; r < 150; r++) begin
      pa = rand_pot();
      model(pa, ew, ev, en);
      run_search(pa, ew, ev, en, "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
